// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit (8 ops) with accumulator, zero flag and output beat counter.
// Optional out_parity output when LOGIC_UNIT_PARITY_EN is defined.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] out_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_acc;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_result;

    // Handshake: a beat moves on a rising edge where valid && ready; the producer holds its
    // beat stable until then. The single output slot is free when empty or draining this cycle.
    assign in_ready   = !r_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_valid && out_ready;

    // acc_clr seeds the accumulator chain from in_a even when acc_en is set.
    assign w_a = (acc_en && !acc_clr) ? r_acc : in_a;

    always_comb begin
        w_result = '0;
        case (in_op)
            OP_AND:  w_result = w_a & in_b;
            OP_OR:   w_result = w_a | in_b;
            OP_XOR:  w_result = w_a ^ in_b;
            OP_NAND: w_result = ~(w_a & in_b);
            OP_NOR:  w_result = ~(w_a | in_b);
            OP_XNOR: w_result = ~(w_a ^ in_b);
            OP_NOTA: w_result = ~w_a;
            OP_PASS: w_result = w_a;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b0;
        end else if (w_in_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_result;
            r_zero  <= (w_result == '0);
        end else if (w_out_xfer) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_in_xfer && (acc_en || acc_clr)) begin
            r_acc <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_out_xfer) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_in_xfer) begin
            r_parity <= ^w_result;
        end
    end

    assign out_parity = r_parity;
`endif

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_zero  = r_zero;
    assign out_count = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: an 8-bit instance (CNT_W=8) and a 1-bit instance (CNT_W=2).
module tb_logic_unit_pipe;

    logic clk;
    logic rst_n;

    // 8-bit instance signals
    logic       in_valid8, in_ready8, acc_en8, acc_clr8, out_valid8, out_ready8, out_zero8;
    logic [7:0] in_a8, in_b8, out_data8, out_count8;
    logic [2:0] in_op8;

    // 1-bit instance signals
    logic       in_valid1, in_ready1, acc_en1, acc_clr1, out_valid1, out_ready1, out_zero1;
    logic [0:0] in_a1, in_b1, out_data1;
    logic [1:0] out_count1;
    logic [2:0] in_op1;

`ifdef LOGIC_UNIT_PARITY_EN
    logic out_parity8, out_parity1;
`endif

    int n_total = 0;
    int n_pass  = 0;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_op(in_op8),
        .acc_en(acc_en8), .acc_clr(acc_clr8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .out_zero(out_zero8),
`ifdef LOGIC_UNIT_PARITY_EN
        .out_parity(out_parity8),
`endif
        .out_count(out_count8)
    );

    logic_unit_pipe #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_op(in_op1),
        .acc_en(acc_en1), .acc_clr(acc_clr1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_zero(out_zero1),
`ifdef LOGIC_UNIT_PARITY_EN
        .out_parity(out_parity1),
`endif
        .out_count(out_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       ae;
        logic       ac;
        logic [7:0] exp_data;
        logic       exp_zero;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];
    logic [3:0] tt[8];  // bit index {a,b} -> expected 1-bit result

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic ae, input logic ac);
        in_valid8 = 1'b1;
        in_a8     = a;
        in_b8     = b;
        in_op8    = op;
        acc_en8   = ae;
        acc_clr8  = ac;
    endtask

    task automatic idle8;
        in_valid8 = 1'b0;
        in_a8     = '0;
        in_b8     = '0;
        in_op8    = '0;
        acc_en8   = 1'b0;
        acc_clr8  = 1'b0;
    endtask

    initial begin
        // Table: ops, then accumulator chain (seed, fold, zero, clr-over-en, hold, pass-acc)
        vecs[0]  = '{8'h0F, 8'hF0, 3'b001, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[1]  = '{8'hF0, 8'h0F, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{8'hAA, 8'hFF, 3'b010, 1'b0, 1'b0, 8'h55, 1'b0};
        vecs[3]  = '{8'hFF, 8'h0F, 3'b011, 1'b0, 1'b0, 8'hF0, 1'b0};
        vecs[4]  = '{8'h0F, 8'h30, 3'b100, 1'b0, 1'b0, 8'hC0, 1'b0};
        vecs[5]  = '{8'hAA, 8'hA5, 3'b101, 1'b0, 1'b0, 8'hF0, 1'b0};
        vecs[6]  = '{8'h3C, 8'hFF, 3'b110, 1'b0, 1'b0, 8'hC3, 1'b0};
        vecs[7]  = '{8'h81, 8'h00, 3'b111, 1'b0, 1'b0, 8'h81, 1'b0};
        vecs[8]  = '{8'hAA, 8'h00, 3'b010, 1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[9]  = '{8'h00, 8'hFF, 3'b010, 1'b1, 1'b0, 8'h55, 1'b0};
        vecs[10] = '{8'hFF, 8'h55, 3'b010, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{8'h0F, 8'h30, 3'b001, 1'b1, 1'b1, 8'h3F, 1'b0};
        vecs[12] = '{8'h11, 8'hFF, 3'b000, 1'b0, 1'b0, 8'h11, 1'b0};
        vecs[13] = '{8'h00, 8'h00, 3'b111, 1'b1, 1'b0, 8'h3F, 1'b0};
        vecs[14] = '{8'h07, 8'h00, 3'b111, 1'b0, 1'b0, 8'h07, 1'b0};

        // AND, OR, XOR, NAND, NOR, XNOR, ~A, A
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;

        // Reset block
        rst_n = 1'b0;
        idle8();
        out_ready8 = 1'b0;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_op1 = '0;
        acc_en1 = 1'b0; acc_clr1 = 1'b0; out_ready1 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_out_data",  32'(out_data8),  32'd0);
        check("rst_out_zero",  32'(out_zero8),  32'd0);
        check("rst_out_count", 32'(out_count8), 32'd0);
        check("rst_in_ready",  32'(in_ready8),  32'd1);
`ifdef LOGIC_UNIT_PARITY_EN
        check("rst_parity", 32'(out_parity8), 32'd0);
`endif

        // Back-to-back table beats with downstream always ready
        out_ready8 = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive8(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ae, vecs[i].ac);
            tick();
            check($sformatf("vec%0d_data", i),  32'(out_data8),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d_zero", i),  32'(out_zero8),  32'(vecs[i].exp_zero));
            check($sformatf("vec%0d_valid", i), 32'(out_valid8), 32'd1);
            check($sformatf("vec%0d_count", i), 32'(out_count8), 32'(i));
`ifdef LOGIC_UNIT_PARITY_EN
            check($sformatf("vec%0d_parity", i), 32'(out_parity8), 32'(^vecs[i].exp_data));
`endif
        end
        idle8();
        tick();
        check("drain_valid", 32'(out_valid8), 32'd0);
        check("drain_data_hold", 32'(out_data8), 32'h07);
        check("drain_count", 32'(out_count8), 32'd15);

        // Stall: second beat must wait until out_ready rises
        out_ready8 = 1'b0;
        drive8(8'h01, 8'h02, 3'b001, 1'b0, 1'b0);
        tick();
        check("stall_first_data", 32'(out_data8), 32'h03);
        check("stall_in_ready", 32'(in_ready8), 32'd0);
        drive8(8'h10, 8'h20, 3'b001, 1'b0, 1'b0);
        tick(); tick();
        check("stall_hold_data", 32'(out_data8), 32'h03);
        check("stall_hold_valid", 32'(out_valid8), 32'd1);
        check("stall_hold_count", 32'(out_count8), 32'd15);
        out_ready8 = 1'b1;
        #1;
        check("stall_release_ready", 32'(in_ready8), 32'd1);
        tick();
        idle8();
        check("stall_second_data", 32'(out_data8), 32'h30);
        check("stall_second_valid", 32'(out_valid8), 32'd1);
        check("stall_count_mid", 32'(out_count8), 32'd16);
        tick();
        check("stall_count_end", 32'(out_count8), 32'd17);
        check("stall_end_valid", 32'(out_valid8), 32'd0);

        // Reset in the middle of a stall with acc=0x5A and count=3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready8 = 1'b1;
        drive8(8'h5A, 8'h00, 3'b111, 1'b0, 1'b1);
        tick();
        drive8(8'h00, 8'h00, 3'b001, 1'b0, 1'b0);
        tick();
        drive8(8'h00, 8'h01, 3'b001, 1'b0, 1'b0);
        tick();
        drive8(8'h00, 8'h02, 3'b001, 1'b0, 1'b0);
        tick();
        idle8();
        out_ready8 = 1'b0;
        tick();
        check("prerst_count", 32'(out_count8), 32'd3);
        check("prerst_valid", 32'(out_valid8), 32'd1);
        check("prerst_data", 32'(out_data8), 32'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid8), 32'd0);
        check("midrst_data", 32'(out_data8), 32'd0);
        check("midrst_count", 32'(out_count8), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", 32'(in_ready8), 32'd1);
        tick();
        out_ready8 = 1'b1;
        drive8(8'hFF, 8'h0C, 3'b001, 1'b1, 1'b0);
        tick();
        idle8();
        check("postrst_acc_zero", 32'(out_data8), 32'h0C);
        check("postrst_count", 32'(out_count8), 32'd0);
        tick();
        check("postrst_drain_count", 32'(out_count8), 32'd1);

        // WIDTH=1 truth tables, back-to-back; count wraps mod 4
        out_ready1 = 1'b1;
        for (int op = 0; op < 8; op++) begin
            for (int idx = 0; idx < 4; idx++) begin
                logic [3:0] row;
                row       = tt[op];
                in_valid1 = 1'b1;
                in_op1    = 3'(op);
                in_a1     = 1'(idx >> 1);
                in_b1     = 1'(idx & 1);
                tick();
                check($sformatf("w1_op%0d_ab%0d", op, idx), 32'(out_data1), 32'(row[idx]));
                check($sformatf("w1_cnt_op%0d_ab%0d", op, idx), 32'(out_count1),
                      32'((op * 4 + idx) % 4));
            end
        end
        in_valid1 = 1'b0;
        tick();
        check("w1_drain_count_wrap", 32'(out_count1), 32'd0);
        check("w1_drain_valid", 32'(out_valid1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
